// File: rtl/fancytimer_driver_if.sv
// Request and timer-pin bundle for fancytimer_driver.
// master = the driver's view; slave = the sequencer/timer side.
interface fancytimer_driver_if;
    logic       start;
    logic [3:0] delay;
    logic       ready;
    logic       data;
    logic       done;
    logic       ack;
    logic       busy;
    logic       complete;
    logic       err;

    modport master (
        input  start, delay, done,
        output ready, data, ack, busy, complete, err
    );

    modport slave (
        output start, delay, done,
        input  ready, data, ack, busy, complete, err
    );
endinterface

// File: rtl/fancytimer_driver.sv
// Serial initiator for the countdown timer: guard zeros, start pattern, 4-bit delay, then done/ack.
// Optional watchdog enabled by defining FANCYTIMER_DRV_TIMEOUT_EN.
module fancytimer_driver #(
    parameter logic [3:0] PATTERN        = 4'b1101,
    parameter int         GUARD_BITS     = 2,
    parameter int         TICKS_PER_UNIT = 1000,
    parameter int         MARGIN         = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    fancytimer_driver_if.master  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GUARD,
        ST_PAT,
        ST_DLY,
        ST_WAIT,
        ST_ACK
    } state_t;

    localparam logic [3:0] GUARD_LAST = 4'(GUARD_BITS - 1);

    state_t     state_reg, state_next;
    logic [3:0] bit_cnt_reg, bit_cnt_next;
    logic [3:0] delay_reg, delay_next;
    logic       data_reg, data_next;
    logic       ack_reg, ack_next;
    logic       complete_reg, complete_next;
    logic       timeout_hit;

    // MSB-first views so the bit counter indexes transmission order directly.
    logic [3:0] pat_seq;
    logic [3:0] dly_seq;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_msb_first
            assign pat_seq[gi] = PATTERN[3 - gi];
            assign dly_seq[gi] = delay_reg[3 - gi];
        end
    endgenerate

`ifdef FANCYTIMER_DRV_TIMEOUT_EN
    logic [15:0] wd_reg, wd_next;
    logic [31:0] wd_limit;
    logic        err_reg, err_next;

    assign wd_limit    = (32'(delay_reg) + 32'd1) * 32'(TICKS_PER_UNIT) + 32'(MARGIN);
    assign timeout_hit = (state_reg == ST_WAIT) && ((32'(wd_reg) + 32'd1) >= wd_limit);
    // Counter is held at zero outside WAIT, so it is already clear on entry.
    assign wd_next     = (state_reg == ST_WAIT) ? wd_reg + 16'd1 : 16'd0;
    assign err_next    = (state_reg == ST_WAIT) && !bus.done && timeout_hit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_reg  <= 16'd0;
            err_reg <= 1'b0;
        end else begin
            wd_reg  <= wd_next;
            err_reg <= err_next;
        end
    end

    assign bus.err = err_reg;
`else
    assign timeout_hit = 1'b0;
    assign bus.err     = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        delay_next    = delay_reg;
        data_next     = 1'b0;
        ack_next      = 1'b0;
        complete_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    delay_next   = bus.delay;
                    bit_cnt_next = 4'd0;
                    state_next   = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (bit_cnt_reg == GUARD_LAST) begin
                    bit_cnt_next = 4'd0;
                    state_next   = ST_PAT;
                end else begin
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                end
            end
            ST_PAT: begin
                data_next = pat_seq[bit_cnt_reg[1:0]];
                if (bit_cnt_reg == 4'd3) begin
                    bit_cnt_next = 4'd0;
                    state_next   = ST_DLY;
                end else begin
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                end
            end
            ST_DLY: begin
                data_next = dly_seq[bit_cnt_reg[1:0]];
                if (bit_cnt_reg == 4'd3) begin
                    bit_cnt_next = 4'd0;
                    state_next   = ST_WAIT;
                end else begin
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                end
            end
            ST_WAIT: begin
                // done takes priority over a simultaneous watchdog expiry.
                if (bus.done) begin
                    ack_next      = 1'b1;
                    complete_next = 1'b1;
                    state_next    = ST_ACK;
                end else if (timeout_hit) begin
                    ack_next   = 1'b1;
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= 4'd0;
            delay_reg    <= 4'd0;
            data_reg     <= 1'b0;
            ack_reg      <= 1'b0;
            complete_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            delay_reg    <= delay_next;
            data_reg     <= data_next;
            ack_reg      <= ack_next;
            complete_reg <= complete_next;
        end
    end

    assign bus.ready    = (state_reg == ST_IDLE);
    assign bus.busy     = (state_reg != ST_IDLE);
    assign bus.data     = data_reg;
    assign bus.ack      = ack_reg;
    assign bus.complete = complete_reg;

endmodule

// File: tb/tb_fancytimer_driver.sv
// Scoreboard bench for fancytimer_driver with a behavioural countdown timer for closed-loop runs.
module tb_fancytimer_driver;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    fancytimer_driver_if bus();

    fancytimer_driver dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit exp_q[$];

    logic man_done = 1'b0;
    logic timer_en = 1'b0;
    logic tm_done;
    int   tm_state;
    int   tm_cnt;
    logic [3:0] tm_sh;
    logic [3:0] tm_d;

    assign bus.done = timer_en ? tm_done : man_done;

    // Timer: hunt for 1101, take 4 delay bits, count (d+1)*1000, hold done until ack.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tm_state <= 0;
            tm_cnt   <= 0;
            tm_sh    <= 4'd0;
            tm_d     <= 4'd0;
            tm_done  <= 1'b0;
        end else begin
            case (tm_state)
                0: begin
                    tm_sh <= {tm_sh[2:0], bus.data};
                    if ({tm_sh[2:0], bus.data} == 4'b1101) begin
                        tm_state <= 1;
                        tm_cnt   <= 0;
                    end
                end
                1: begin
                    tm_d <= {tm_d[2:0], bus.data};
                    if (tm_cnt == 3) begin
                        tm_state <= 2;
                        tm_cnt   <= (int'({tm_d[2:0], bus.data}) + 1) * 1000;
                    end else begin
                        tm_cnt <= tm_cnt + 1;
                    end
                end
                2: begin
                    if (tm_cnt <= 1) begin
                        tm_done  <= 1'b1;
                        tm_state <= 3;
                    end else begin
                        tm_cnt <= tm_cnt - 1;
                    end
                end
                default: begin
                    if (bus.ack) begin
                        tm_done  <= 1'b0;
                        tm_state <= 0;
                        tm_sh    <= 4'd0;
                    end
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line after acceptance edges E1..E11: guard, pattern, delay, idle zero.
    task automatic push_frame(input logic [3:0] d);
        logic [3:0] pat;
        pat = 4'b1101;
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        for (int i = 3; i >= 0; i--) exp_q.push_back(pat[i]);
        for (int i = 3; i >= 0; i--) exp_q.push_back(d[i]);
        exp_q.push_back(1'b0);
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.delay = 4'd0;
        #2 resetn = 1'b0;
        #10;
        n_cmp++;
        if ({bus.ready, bus.busy, bus.data, bus.ack, bus.complete, bus.err} !== 6'b100000) begin
            n_bad++;
            $display("FAIL reset_outputs: got %06b want 100000",
                     {bus.ready, bus.busy, bus.data, bus.ack, bus.complete, bus.err});
        end
        @(negedge clk);
        resetn = 1'b1;
        tick();
        $display("reset released");
    endtask

    task automatic test_serial();
        bit e;
        int k;
        bus.start = 1'b1;
        bus.delay = 4'hA;
        push_frame(4'hA);
        tick();
        bus.start = 1'b0;
        k = 0;
        while (exp_q.size() > 0) begin
            tick();
            k++;
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.data !== e) begin
                n_bad++;
                $display("FAIL serial_bit_E%0d: got %0b want %0b", k, bus.data, e);
            end
            n_cmp++;
            if ({bus.ready, bus.busy} !== 2'b01) begin
                n_bad++;
                $display("FAIL serial_ready_busy_E%0d: got %02b want 01", k, {bus.ready, bus.busy});
            end
        end
        $display("frame delay=A sent");
    endtask

    task automatic test_done_ack();
        int early;
        early = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.ack !== 1'b0 || bus.busy !== 1'b1) early++;
        end
        n_cmp++;
        if (early != 0) begin
            n_bad++;
            $display("FAIL wait_hold: got %0d bad cycles want 0", early);
        end
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        n_cmp++;
        if ({bus.ack, bus.complete, bus.err, bus.ready} !== 4'b1100) begin
            n_bad++;
            $display("FAIL ack_pulse: got %04b want 1100", {bus.ack, bus.complete, bus.err, bus.ready});
        end
        tick();
        n_cmp++;
        if ({bus.ack, bus.complete, bus.ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL after_ack: got %03b want 001", {bus.ack, bus.complete, bus.ready});
        end
        $display("run completed via done");
    endtask

    task automatic test_ignored();
        bit e;
        int k;
        int stray;
        bus.start = 1'b1;
        bus.delay = 4'hA;
        man_done  = 1'b1;
        push_frame(4'hA);
        tick();
        bus.start = 1'b0;
        k = 0;
        while (exp_q.size() > 0) begin
            tick();
            k++;
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.data !== e) begin
                n_bad++;
                $display("FAIL ignored_bit_E%0d: got %0b want %0b", k, bus.data, e);
            end
            if (k == 11) begin
                n_cmp++;
                if ({bus.ack, bus.complete} !== 2'b11) begin
                    n_bad++;
                    $display("FAIL early_done_ack: got %02b want 11", {bus.ack, bus.complete});
                end
            end
            bus.start = (k >= 2 && k <= 5);
            if (k == 7) bus.delay = 4'h3;
        end
        man_done  = 1'b0;
        bus.start = 1'b0;
        tick();
        n_cmp++;
        if ({bus.ready, bus.ack} !== 2'b10) begin
            n_bad++;
            $display("FAIL ignored_idle: got %02b want 10", {bus.ready, bus.ack});
        end
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.busy !== 1'b0 || bus.data !== 1'b0) stray++;
        end
        n_cmp++;
        if (stray != 0) begin
            n_bad++;
            $display("FAIL no_second_run: got %0d busy cycles want 0", stray);
        end
        $display("frame with stray start/delay checked");
    endtask

    task automatic test_async_reset();
        bit e;
        int k;
        bus.start = 1'b1;
        bus.delay = 4'h5;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        n_cmp++;
        if (bus.data !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_dly_bit: got %0b want 1", bus.data);
        end
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if ({bus.data, bus.ack, bus.busy, bus.ready} !== 4'b0001) begin
            n_bad++;
            $display("FAIL async_reset: got %04b want 0001", {bus.data, bus.ack, bus.busy, bus.ready});
        end
        #1 resetn = 1'b1;
        tick();
        bus.start = 1'b1;
        bus.delay = 4'h5;
        push_frame(4'h5);
        tick();
        bus.start = 1'b0;
        k = 0;
        while (exp_q.size() > 0) begin
            tick();
            k++;
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.data !== e) begin
                n_bad++;
                $display("FAIL post_reset_bit_E%0d: got %0b want %0b", k, bus.data, e);
            end
        end
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        tick();
        n_cmp++;
        if (bus.ready !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset_release: ready got %0b want 1", bus.ready);
        end
        $display("async reset mid-frame checked");
    endtask

`ifdef FANCYTIMER_DRV_TIMEOUT_EN
    task automatic test_timeout();
        int early;
        for (int pass = 0; pass < 2; pass++) begin
            early = 0;
            bus.start = 1'b1;
            bus.delay = 4'h0;
            tick();
            bus.start = 1'b0;
            for (int k = 1; k < 1026; k++) begin
                tick();
                if (bus.ack !== 1'b0) early++;
                if (pass == 1 && k == 1025) man_done = 1'b1;
            end
            tick();
            man_done = 1'b0;
            n_cmp++;
            if (early != 0) begin
                n_bad++;
                $display("FAIL wd_early_p%0d: got %0d ack cycles want 0", pass, early);
            end
            n_cmp++;
            if (pass == 0 && {bus.ack, bus.err, bus.complete} !== 3'b110) begin
                n_bad++;
                $display("FAIL wd_expiry: got %03b want 110", {bus.ack, bus.err, bus.complete});
            end else if (pass == 1 && {bus.ack, bus.err, bus.complete} !== 3'b101) begin
                n_bad++;
                $display("FAIL wd_done_wins: got %03b want 101", {bus.ack, bus.err, bus.complete});
            end
            tick();
            n_cmp++;
            if ({bus.err, bus.ready} !== 2'b01) begin
                n_bad++;
                $display("FAIL wd_after_p%0d: got %02b want 01", pass, {bus.err, bus.ready});
            end
            $display("watchdog pass %0d done", pass);
        end
    endtask
`else
    task automatic test_no_timeout();
        int bad;
        bad = 0;
        bus.start = 1'b1;
        bus.delay = 4'h0;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            tick();
            if (bus.err !== 1'b0 || bus.ack !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL no_watchdog: got %0d bad cycles busy=%0b want 0 busy=1", bad, bus.busy);
        end
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        tick();
        n_cmp++;
        if (bus.ready !== 1'b1) begin
            n_bad++;
            $display("FAIL no_watchdog_release: ready got %0b want 1", bus.ready);
        end
        $display("20000-cycle wait without watchdog done");
    endtask
`endif

    task automatic test_closed_loop();
        int cycles;
        int lo;
        int hi;
        bit seen;
        #2 resetn = 1'b0;
        #2 resetn = 1'b1;
        timer_en = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) begin
            bus.start = 1'b1;
            bus.delay = 4'(d);
            tick();
            bus.start = 1'b0;
            cycles = 0;
            seen = 1'b0;
            while (!seen && cycles < 5000) begin
                tick();
                cycles++;
                if (bus.ack === 1'b1) seen = 1'b1;
            end
            lo = (d + 1) * 1000;
            hi = lo + 20;
            n_cmp++;
            if (!seen || cycles < lo || cycles > hi) begin
                n_bad++;
                $display("FAIL loop_latency_d%0d: got %0d cycles seen=%0b want %0d..%0d", d, cycles, seen, lo, hi);
            end
            tick();
            n_cmp++;
            if ({bus.ack, bus.ready, tm_done} !== 3'b010 || tm_state != 0) begin
                n_bad++;
                $display("FAIL loop_release_d%0d: got ack/ready/done %03b tstate %0d want 010 tstate 0",
                         d, {bus.ack, bus.ready, tm_done}, tm_state);
            end
            $display("closed-loop run delay=%0d took %0d cycles", d, cycles);
        end
        timer_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_serial();
        test_done_ack();
        test_ignored();
        test_async_reset();
`ifdef FANCYTIMER_DRV_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_closed_loop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fancytimer_driver.md
Name: fancytimer_driver

Overview:
- Initiator for the serial-programmed countdown timer. Accepts a 4-bit delay request on a parallel valid/ready interface.
- Serialises a guard gap, the 1101 start pattern and the delay (MSB first) onto the timer's data line.
- Waits for the timer's done, then returns ack to release it.
- Sits between the control sequencer and the timer's data/done/ack pins; the sequencer sees one request and one completion pulse per timing run.

Parameters:
- PATTERN, 4'b1101, start pattern, sent MSB first.
- GUARD_BITS, 2, zero bits driven before the pattern (range 1..15).
- TICKS_PER_UNIT, 1000, timer clocks per delay unit; used only by the optional watchdog.
- MARGIN, 16, extra watchdog slack in cycles.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request valid
- delay  in  4  delay code; timer runs (delay+1)*TICKS_PER_UNIT cycles
- ready  out  1  high only in IDLE; request accepted on start&&ready at a clk edge
- data  out  1  serial line to timer, registered
- done  in  1  timer finished flag
- ack  out  1  acknowledge to timer, registered, one-cycle pulse
- busy  out  1  high in every state except IDLE
- complete  out  1  one-cycle pulse when a run finishes normally
- err  out  1  one-cycle watchdog pulse (optional feature only; else constant 0)

Behaviour:
- Reset (resetn=0, takes effect immediately, no clock needed):
  - state=IDLE; data=0, ack=0, complete=0, err=0.
  - Delay latch cleared; bit and watchdog counters cleared; ready=1, busy=0.
- States and transitions:
  - IDLE: data=0. On start&&ready, latch delay and go to GUARD. Otherwise stay.
  - GUARD: data=0 for GUARD_BITS cycles, then go to PAT.
  - PAT: data=PATTERN[3],[2],[1],[0] on 4 consecutive cycles, then go to DLY.
  - DLY: data=delay_latched[3],[2],[1],[0] on 4 consecutive cycles, then go to WAIT.
  - WAIT: data=0. When done is sampled 1, go to ACK.
  - ACK: ack=1 and complete=1 for exactly this one cycle, data=0, then go to IDLE.
- Timing with GUARD_BITS=2 and acceptance at edge E0:
  - data values after edges E1..E10 are 0,0,1,1,0,1,d3,d2,d1,d0.
  - data returns to 0 after E11.
- ready is combinational from state. It drops on the cycle after acceptance; back-to-back requests are impossible.
- start while not ready: ignored, no queueing.
- delay changes after acceptance: no effect; the latched copy is used.
- done outside WAIT: ignored.
- done already high on WAIT entry: go to ACK on the next edge.
- After ACK the design is in IDLE; a new start is accepted on the next edge. The line stays 0 through at least GUARD_BITS cycles before the next pattern.
- Single driver of data. data is never high outside PAT or DLY.
- Counters are sized to the largest count they hold; no wrap-around occurs within a run.

Optional Feature:
- Macro: FANCYTIMER_DRV_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit watchdog clears on WAIT entry and increments every WAIT cycle.
  - If it reaches (delay_latched+1)*TICKS_PER_UNIT+MARGIN before done, go to ACK.
  - In that ACK cycle: ack=1, err=1, complete=0. The timer is force-released.
  - If done and expiry occur in the same cycle, done wins: complete=1, err=0.
- Without the macro: no watchdog logic, err tied to 0, WAIT holds indefinitely until done.

Test Plan:
- Reset, then start=1 with delay=4'hA, GUARD_BITS=2 -> data sequence 0,0,1,1,0,1,1,0,1,0 after E1..E10; ready=0 and busy=1 from E1.
- In WAIT, raise done 50 cycles later -> ack=1 and complete=1 for exactly one cycle on the next edge; ready=1 the cycle after.
- start pulses during PAT, and delay changed to 4'h3 mid-DLY -> both ignored; transmitted bits still encode 4'hA; no second run.
- Assert resetn=0 between clock edges mid-DLY -> data, ack and busy drop to 0 without waiting for a clk edge; ready=1; after release, a new start begins with the guard bits.
- Closed loop against the timer with delay=0: after ~1000 timer cycles the timer's done is followed by one ack pulse; the timer returns to pattern search; a second run with delay=1 takes ~2000 cycles.
- FANCYTIMER_DRV_TIMEOUT_EN defined, delay=0, done held 0 -> ack=1, err=1, complete=0 exactly 1016 cycles after WAIT entry; without the macro, still in WAIT after 20000 cycles with err=0.
